ccg_sweep_eval: RTL and testbench
=================================

CCG_SWEEP_EVAL -- requirements
Module: ccg_sweep_eval

Interface
REQ-001 The block SHALL have parameter N_IN, default 3, giving the number of function inputs (1..10).
REQ-002 The block SHALL have parameter N_OUT, default 6, giving the number of function outputs (1..SIG_W).
REQ-003 The block SHALL have parameter SIG_W, default 16, giving the signature register width.
REQ-004 The block SHALL have parameter POLY, default 16'h1021, giving the MISR feedback polynomial (SIG_W bits).
REQ-005 The block SHALL have parameter SEED, default 0, giving the signature value loaded at sweep start (SIG_W bits).
REQ-006 Ports SHALL be:
  clk  in  1  single clock; all state updates on its rising edge
  rst  in  1  synchronous reset, active-high
  lut_we  in  1  truth-table write strobe
  lut_addr  in  N_IN  truth-table write address (input vector)
  lut_wdata  in  N_OUT  truth-table write data (output vector)
  eval_valid  in  1  single-vector evaluation request
  eval_in  in  N_IN  input vector to evaluate
  eval_out_valid  out  1  evaluation result valid
  eval_out  out  N_OUT  evaluation result
  start  in  1  sweep start request
  busy  out  1  sweep in progress
  done  out  1  one-cycle sweep-complete pulse
  signature  out  SIG_W  sweep signature

Function
REQ-007 The block SHALL hold a 2^N_IN x N_OUT truth table (TT); TT[a] is the output vector of the function for input vector a.
REQ-008 When lut_we=1 and busy=0, TT[lut_addr] SHALL take lut_wdata at that edge; when busy=1, lut_we SHALL be ignored.
REQ-009 Evaluation SHALL have 1-cycle latency: eval_valid=1 at edge k gives eval_out_valid=1 and eval_out=TT[eval_in] (value before any write at edge k) after edge k; otherwise eval_out_valid=0 and eval_out holds its last value.
REQ-010 Evaluation SHALL operate independently of sweep state.
REQ-011 The controller SHALL have states IDLE, SWEEP, DONE.
REQ-012 IDLE: start=1 SHALL go to SWEEP, with cnt=0 and signature=SEED; start=0 SHALL stay in IDLE.
REQ-013 SWEEP: each cycle, signature SHALL take ((signature<<1) truncated to SIG_W) XOR (POLY if signature[SIG_W-1]=1, else 0) XOR zero-extended TT[cnt], and cnt SHALL increment.
REQ-014 SWEEP: after the update with cnt=2^N_IN-1, the state SHALL go to DONE; cnt SHALL wrap to 0, with no overflow flag.
REQ-015 DONE SHALL last exactly one cycle, then go to IDLE.
REQ-016 busy SHALL be 1 in SWEEP only; done SHALL be 1 in DONE only.
REQ-017 start in SWEEP or DONE SHALL be ignored; a new sweep needs start in IDLE.
REQ-018 Sweep latency: start sampled at edge k SHALL give done=1 in the cycle after edge k+2^N_IN.
REQ-019 signature SHALL hold its final value from DONE until the next accepted start.
REQ-020 start and lut_we in the same IDLE cycle SHALL both take effect; the write SHALL be visible to the sweep.

Reset
REQ-021 rst=1 at an edge SHALL set state=IDLE, cnt=0, busy=0, done=0, eval_out_valid=0, eval_out=0, signature=0, and every TT entry to 0.
REQ-022 rst SHALL take priority over start, lut_we and eval_valid in the same cycle.
REQ-023 rst during SWEEP SHALL abort the sweep with no done pulse.

Verification (N_IN=3, N_OUT=6, SIG_W=16, POLY=16'h1021, SEED=0 unless stated)
REQ-024 Reset, no writes, start -> busy=1 for 8 cycles, done pulse in the 9th cycle after the start edge, signature=16'h0000.
REQ-025 Write TT[0]=6'h01 only, start -> signature=16'h0080.
REQ-026 Write TT[7]=6'h01 only, start -> signature=16'h0001.
REQ-027 Write TT[5]=6'h2A; eval_valid=1 with eval_in=5 plus a same-cycle lut_we to address 5 with data 6'h15 -> next cycle eval_out_valid=1, eval_out=6'h2A; re-evaluate -> eval_out=6'h15.
REQ-028 Mid-sweep start and lut_we (TT[2]=6'h3F) -> no restart, TT[2] unchanged (eval returns 0), signature identical to the undisturbed run.
REQ-029 Assert rst in the 4th SWEEP cycle -> busy=0, done never pulses, signature=0, all TT entries read 0.

Source files
------------

// File: rtl/ccg_sweep_eval.sv
// Truth-table function evaluator with single-vector lookup and a full
// input-space sweep that compresses every table entry into a MISR signature.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start; table writable; signature holds
// ST_SWEEP | one table entry folded into the signature per cycle; busy=1
// ST_DONE  | single-cycle completion pulse; done=1
module ccg_sweep_eval #(
    parameter int               N_IN  = 3,
    parameter int               N_OUT = 6,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lut_we,
    input  logic [N_IN-1:0]  lut_addr,
    input  logic [N_OUT-1:0] lut_wdata,
    input  logic             eval_valid,
    input  logic [N_IN-1:0]  eval_in,
    output logic             eval_out_valid,
    output logic [N_OUT-1:0] eval_out,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature
);

    localparam int DEPTH = 1 << N_IN;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_IN-1:0]    cnt_q, cnt_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic               eval_valid_q, eval_valid_d;
    logic [N_OUT-1:0]   eval_out_q, eval_out_d;
    logic [N_OUT-1:0]   tt_q [DEPTH];
    logic [N_OUT-1:0]   tt_d [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sig_q        <= '0;
            eval_valid_q <= 1'b0;
            eval_out_q   <= '0;
            tt_q         <= '{default: '0};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sig_q        <= sig_d;
            eval_valid_q <= eval_valid_d;
            eval_out_q   <= eval_out_d;
            tt_q         <= tt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sig_d        = sig_q;
        tt_d         = tt_q;
        eval_valid_d = eval_valid;
        eval_out_d   = eval_valid ? tt_q[eval_in] : eval_out_q;

        // Table is frozen while sweeping so the signature reflects one snapshot.
        if (lut_we && (state_q != ST_SWEEP)) begin
            tt_d[lut_addr] = lut_wdata;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                    sig_d   = SEED;
                end
            end
            ST_SWEEP: begin
                sig_d = (sig_q << 1)
                      ^ (sig_q[SIG_W-1] ? POLY : '0)
                      ^ SIG_W'(tt_q[cnt_q]);
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy           = (state_q == ST_SWEEP);
    assign done           = (state_q == ST_DONE);
    assign signature      = sig_q;
    assign eval_out_valid = eval_valid_q;
    assign eval_out       = eval_out_q;

endmodule

// File: tb/tb_ccg_sweep_eval.sv
// Randomised self-checking bench for ccg_sweep_eval against a table/arith model.
module tb_ccg_sweep_eval;

    logic        clk = 1'b0;
    logic        rst;
    logic        lut_we;
    logic [2:0]  lut_addr;
    logic [5:0]  lut_wdata;
    logic        eval_valid;
    logic [2:0]  eval_in;
    logic        eval_out_valid;
    logic [5:0]  eval_out;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] signature;

    int checks = 0;
    int errors = 0;

    logic [5:0] tt_m [8];

    ccg_sweep_eval dut (
        .clk(clk), .rst(rst),
        .lut_we(lut_we), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
        .eval_valid(eval_valid), .eval_in(eval_in),
        .eval_out_valid(eval_out_valid), .eval_out(eval_out),
        .start(start), .busy(busy), .done(done), .signature(signature)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [15:0] sig_model();
        int s;
        int fb;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            fb = (s >= 32768) ? 32'h1021 : 0;
            s  = ((s * 2) % 65536) ^ fb ^ int'(tt_m[i]);
        end
        return s[15:0];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) tt_m[i] = '0;
    endtask

    task automatic lut_write(input logic [2:0] a, input logic [5:0] d);
        lut_we = 1'b1; lut_addr = a; lut_wdata = d;
        tick();
        lut_we = 1'b0;
        tt_m[a] = d;
    endtask

    task automatic eval_read(input logic [2:0] a, output logic [5:0] d, output logic v);
        eval_valid = 1'b1; eval_in = a;
        tick();
        eval_valid = 1'b0;
        d = eval_out; v = eval_out_valid;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
    endtask

    // Start a sweep (optionally with a same-cycle write), optionally poke
    // start+write at sweep cycle disturb_at, and record busy/done over 14 cycles.
    task automatic run_sweep(input bit co_we, input logic [2:0] co_a, input logic [5:0] co_d,
                             input int disturb_at,
                             output int busy_n, output int done_n, output int done_at);
        start = 1'b1;
        if (co_we) begin
            lut_we = 1'b1; lut_addr = co_a; lut_wdata = co_d; tt_m[co_a] = co_d;
        end
        tick();
        start = 1'b0; lut_we = 1'b0;
        busy_n = 0; done_n = 0; done_at = -1;
        for (int c = 0; c < 14; c++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
            if (c == disturb_at) begin
                start = 1'b1; lut_we = 1'b1; lut_addr = 3'd2; lut_wdata = 6'h3F;
            end
            tick();
            start = 1'b0; lut_we = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [5:0] d; logic v;
        rst = 1'b1; start = 1'b1; lut_we = 1'b1; lut_addr = 3'd1; lut_wdata = 6'h11;
        eval_valid = 1'b1; eval_in = 3'd1;
        tick();
        rst = 1'b0; start = 1'b0; lut_we = 1'b0; eval_valid = 1'b0;
        clear_model();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || eval_out_valid !== 1'b0 ||
            eval_out !== 6'h00 || signature !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b eov=%b eo=%h sig=%h, required 0 0 0 00 0000",
                     busy, done, eval_out_valid, eval_out, signature);
        end
        eval_read(3'd1, d, v);
        checks++;
        if (d !== 6'h00 || v !== 1'b1) begin
            errors++;
            $display("FAIL reset_tt_entry1: got %h valid %b, required 00 valid 1", d, v);
        end
    endtask

    task automatic test_sweep_known();
        int b, dn, da;
        run_sweep(1'b0, 3'd0, 6'd0, -1, b, dn, da);
        checks++;
        if (b !== 8 || dn !== 1 || da !== 8) begin
            errors++;
            $display("FAIL sweep_timing: busy=%0d done=%0d at=%0d, required 8 1 8", b, dn, da);
        end
        checks++;
        if (signature !== 16'h0000) begin
            errors++;
            $display("FAIL sweep_zero_sig: got %h required 0000", signature);
        end
        lut_write(3'd0, 6'h01);
        run_sweep(1'b0, 3'd0, 6'd0, -1, b, dn, da);
        checks++;
        if (signature !== 16'h0080) begin
            errors++;
            $display("FAIL sweep_tt0_sig: got %h required 0080", signature);
        end
        do_reset();
        lut_write(3'd7, 6'h01);
        run_sweep(1'b0, 3'd0, 6'd0, -1, b, dn, da);
        checks++;
        if (signature !== 16'h0001) begin
            errors++;
            $display("FAIL sweep_tt7_sig: got %h required 0001", signature);
        end
    endtask

    task automatic test_eval_collision();
        logic [5:0] d; logic v;
        do_reset();
        lut_write(3'd5, 6'h2A);
        eval_valid = 1'b1; eval_in = 3'd5;
        lut_we = 1'b1; lut_addr = 3'd5; lut_wdata = 6'h15;
        tick();
        eval_valid = 1'b0; lut_we = 1'b0; tt_m[5] = 6'h15;
        checks++;
        if (eval_out_valid !== 1'b1 || eval_out !== 6'h2A) begin
            errors++;
            $display("FAIL eval_old_value: valid %b out %h, required 1 2a", eval_out_valid, eval_out);
        end
        tick();
        checks++;
        if (eval_out_valid !== 1'b0 || eval_out !== 6'h2A) begin
            errors++;
            $display("FAIL eval_hold: valid %b out %h, required 0 2a", eval_out_valid, eval_out);
        end
        eval_read(3'd5, d, v);
        checks++;
        if (d !== 6'h15 || v !== 1'b1) begin
            errors++;
            $display("FAIL eval_new_value: got %h valid %b, required 15 valid 1", d, v);
        end
    endtask

    task automatic test_random_sweeps();
        int b, dn, da;
        logic [5:0] d; logic v;
        for (int it = 0; it < 5; it++) begin
            for (int k = 0; k < 10; k++) lut_write(3'($urandom_range(0, 7)), 6'($urandom));
            run_sweep(1'b0, 3'd0, 6'd0, -1, b, dn, da);
            checks++;
            if (signature !== sig_model() || b !== 8 || dn !== 1 || da !== 8) begin
                errors++;
                $display("FAIL rand_sweep%0d: sig %h busy %0d done %0d at %0d, required %h 8 1 8",
                         it, signature, b, dn, da, sig_model());
            end
            for (int a = 0; a < 8; a++) begin
                eval_read(3'(a), d, v);
                checks++;
                if (d !== tt_m[a] || v !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_eval%0d_%0d: got %h valid %b, required %h valid 1",
                             it, a, d, v, tt_m[a]);
                end
            end
        end
    endtask

    task automatic test_start_with_write();
        int b, dn, da;
        logic [2:0] a;
        logic [5:0] d;
        a = 3'($urandom_range(0, 7));
        d = 6'($urandom_range(1, 63));
        run_sweep(1'b1, a, d, -1, b, dn, da);
        checks++;
        if (signature !== sig_model() || dn !== 1) begin
            errors++;
            $display("FAIL start_with_write: sig %h done %0d, required %h 1", signature, dn, sig_model());
        end
    endtask

    task automatic test_midsweep_ignore();
        int b, dn, da;
        logic [5:0] d; logic v;
        do_reset();
        for (int i = 0; i < 8; i++) if (i != 2) lut_write(3'(i), 6'($urandom));
        run_sweep(1'b0, 3'd0, 6'd0, 3, b, dn, da);
        checks++;
        if (b !== 8 || dn !== 1 || da !== 8) begin
            errors++;
            $display("FAIL midsweep_timing: busy %0d done %0d at %0d, required 8 1 8", b, dn, da);
        end
        checks++;
        if (signature !== sig_model()) begin
            errors++;
            $display("FAIL midsweep_sig: got %h required %h", signature, sig_model());
        end
        eval_read(3'd2, d, v);
        checks++;
        if (d !== 6'h00) begin
            errors++;
            $display("FAIL midsweep_tt2: got %h required 00", d);
        end
    endtask

    task automatic test_back_to_back();
        int dpos [$];
        int done_n;
        logic [15:0] exp_sig;
        exp_sig = sig_model();
        start = 1'b1;
        tick();
        for (int c = 0; c < 25; c++) begin
            if (done) dpos.push_back(c);
            tick();
        end
        start = 1'b0;
        done_n = dpos.size();
        checks++;
        if (done_n < 2 || dpos[0] !== 8 || dpos[1] !== 18) begin
            errors++;
            $display("FAIL back_to_back_done: count %0d first %0d second %0d, required >=2 8 18",
                     done_n, (done_n > 0) ? dpos[0] : -1, (done_n > 1) ? dpos[1] : -1);
        end
        for (int c = 0; c < 12 && busy; c++) tick();
        checks++;
        if (busy !== 1'b0 || signature !== exp_sig) begin
            errors++;
            $display("FAIL back_to_back_sig: busy %b sig %h, required 0 %h", busy, signature, exp_sig);
        end
    endtask

    task automatic test_reset_abort();
        int dn;
        logic [5:0] d; logic v;
        for (int i = 0; i < 8; i++) lut_write(3'(i), 6'($urandom_range(1, 63)));
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        dn = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) dn++;
            tick();
        end
        checks++;
        if (dn !== 0 || busy !== 1'b0 || signature !== 16'h0000) begin
            errors++;
            $display("FAIL abort_state: done %0d busy %b sig %h, required 0 0 0000", dn, busy, signature);
        end
        for (int a = 0; a < 8; a++) begin
            eval_read(3'(a), d, v);
            checks++;
            if (d !== 6'h00) begin
                errors++;
                $display("FAIL abort_tt%0d: got %h required 00", a, d);
            end
        end
    endtask

    initial begin
        rst = 1'b0; lut_we = 1'b0; lut_addr = '0; lut_wdata = '0;
        eval_valid = 1'b0; eval_in = '0; start = 1'b0;
        clear_model();
        @(negedge clk);
        test_reset();
        test_sweep_known();
        test_eval_collision();
        test_random_sweeps();
        test_start_with_write();
        test_midsweep_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
